// File: rtl/configf_responder.sv
// configf serial responder: synchronizes cs_n/sclk/mosi, decodes addr+data frames into a 16-bit register bank.
// Latency SYNC_STAGES+2 clk from SCLK edge to MISO/write strobe; no backpressure, a frame is accepted whenever cs_n is low.
module configf_responder #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entity_cs_n,
  input  logic        entity_clk,
  input  logic        entity_mosi,
  output logic        entity_miso,
  output logic        reg_wr_pulse,
  output logic [6:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  input  logic [6:0]  core_rd_addr,
  output logic [15:0] core_rd_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA_WR, DATA_RD, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
  logic        sck_dly_q, sck_dly_d, rise_q, rise_d, fall_q, fall_d;
  logic        mosi_dly_q, mosi_dly_d, cs_dly_q, cs_dly_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic [14:0] wdata_q, wdata_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] regs_d [NUM_REGS];
  logic        wr_pulse_q, wr_pulse_d, frame_err_q, frame_err_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d, core_rd_q, core_rd_d;
  logic        abort, addr_mapped;
  logic [6:0]  byte_nxt;
  logic [15:0] word_nxt, rd_word;

  // Edge strobes, mosi and cs_n are all delayed by one clk so they stay aligned.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], entity_cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], entity_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], entity_mosi};
    sck_dly_d   = sck_sync_q[SYNC_STAGES-1];
    rise_d      = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
    fall_d      = ~sck_sync_q[SYNC_STAGES-1] & sck_dly_q;
    mosi_dly_d  = mosi_sync_q[SYNC_STAGES-1];
    cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
  end

  assign abort       = cs_dly_q && (state_q == ADDR || state_q == DATA_WR || state_q == DATA_RD);
  assign addr_mapped = int'(addr_q) < NUM_REGS;
  assign byte_nxt    = {addr_q[5:0], mosi_dly_q};
  assign word_nxt    = {wdata_q, mosi_dly_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // addr_q[6] holds the first address bit, i.e. the write flag, when the 8th bit arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_dly_q) state_d = ADDR;
      ADDR: begin
        if (abort) state_d = IDLE;
        else if (rise_q && cnt_q == 4'd7) state_d = addr_q[6] ? DATA_WR : DATA_RD;
      end
      DATA_WR, DATA_RD: begin
        if (abort) state_d = IDLE;
        else if (rise_q && cnt_q == 4'd15) state_d = DONE;
      end
      DONE:    if (cs_dly_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_d        = tx_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = abort;
    rd_word     = 16'h0000;
    core_rd_d   = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (byte_nxt == 7'(i)) rd_word = regs_q[i];
      if (core_rd_addr == 7'(i)) core_rd_d = regs_q[i];
    end
    case (state_q)
      IDLE: cnt_d = 4'd0;
      ADDR: if (!abort && rise_q) begin
        addr_d = byte_nxt;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          cnt_d = 4'd0;
          tx_d  = rd_word;
        end
      end
      DATA_WR: if (!abort && rise_q) begin
        wdata_d = word_nxt[14:0];
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15 && addr_mapped) begin
          wr_pulse_d = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = word_nxt;
          for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == 7'(i)) regs_d[i] = word_nxt;
        end
      end
      DATA_RD: if (!abort) begin
        if (rise_q) cnt_d = cnt_q + 4'd1;
        if (fall_q) tx_d = {tx_q[14:0], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      cnt_q       <= 4'd0;
      addr_q      <= 7'd0;
      wdata_q     <= 15'd0;
      tx_q        <= 16'h0000;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0000;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 16'h0000;
      core_rd_q   <= 16'h0000;
      frame_err_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      mosi_dly_q  <= mosi_dly_d;
      cs_dly_q    <= cs_dly_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      core_rd_q   <= core_rd_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    entity_miso  = (state_q == DATA_RD) & tx_q[15];
    reg_wr_pulse = wr_pulse_q;
    reg_wr_addr  = wr_addr_q;
    reg_wr_data  = wr_data_q;
    core_rd_data = core_rd_q;
    frame_err    = frame_err_q;
  end

endmodule

// File: tb/tb_configf_responder.sv
// Directed and randomized frames against a register-bank reference model of the configf responder.
module tb_configf_responder;
  localparam int NR   = 16;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset, cs_n, sclk, mosi, miso, wp, ferr;
  logic [6:0]  wa, core_rd_addr;
  logic [15:0] wd, crd;

  always #5 clk = ~clk;

  configf_responder #(.NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .entity_cs_n(cs_n), .entity_clk(sclk), .entity_mosi(mosi),
    .entity_miso(miso), .reg_wr_pulse(wp), .reg_wr_addr(wa), .reg_wr_data(wd),
    .core_rd_addr(core_rd_addr), .core_rd_data(crd), .frame_err(ferr)
  );

  int checks = 0, failures = 0;
  int wr_cnt = 0, err_cnt = 0;
  logic [6:0]  last_wa = '0;
  logic [15:0] last_wd = '0;
  logic [15:0] model [0:127];

  // Counts strobe cycles, so a strobe wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (wp) begin wr_cnt++; last_wa = wa; last_wd = wd; end
    if (ferr) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] expect_rd(input logic [6:0] idx);
    return (int'(idx) < NR) ? model[idx] : 16'h0000;
  endfunction

  // Master samples MISO just before each falling edge; bit 15 is taken at the 8th clock.
  task automatic frame(input logic [7:0] a, input logic [15:0] d, input int nbits, input int rst_at,
                       output logic [15:0] rd, output logic stray);
    logic [23:0] bits;
    bits  = {a, d};
    rd    = 16'h0000;
    stray = 1'b0;
    cs_n  = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 24) ? bits[23-i] : 1'($urandom);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      if (i == rst_at) begin
        reset = 1'b1;
        tick(2);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_wp", {31'd0, wp}, 32'd0);
        check("rst_wa", {25'd0, wa}, 32'd0);
        check("rst_wd", {16'd0, wd}, 32'd0);
        check("rst_crd", {16'd0, crd}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        for (int j = 0; j < 128; j++) model[j] = 16'h0000;
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(SS + 4);
        return;
      end
      if (i >= 7 && i <= 22) rd[22-i] = miso;
      else if (miso) stray = 1'b1;
      sclk = 1'b0;
    end
    tick(HALF);
    if (miso) stray = 1'b1;
    cs_n = 1'b1;
    tick(SS + 4);
    if (miso) stray = 1'b1;
  endtask

  task automatic core_read(input logic [6:0] idx, input string tag);
    core_rd_addr = idx;
    tick(2);
    check(tag, {16'd0, crd}, {16'd0, expect_rd(idx)});
  endtask

  initial begin
    logic [15:0] rd;
    logic        stray;
    int          w0, e0;
    logic [6:0]  idx;
    logic [15:0] dat;
    logic        is_wr;

    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; core_rd_addr = 7'd0;
    for (int j = 0; j < 128; j++) model[j] = 16'h0000;
    tick(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_wp", {31'd0, wp}, 32'd0);
    check("reset_wa", {25'd0, wa}, 32'd0);
    check("reset_wd", {16'd0, wd}, 32'd0);
    check("reset_crd", {16'd0, crd}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    reset = 1'b0;
    tick(3);

    // Basic write then read of register 3.
    w0 = wr_cnt;
    frame(8'h83, 16'hA5C3, 24, -1, rd, stray);
    model[3] = 16'hA5C3;
    check("wr3_pulses", wr_cnt - w0, 1);
    check("wr3_addr", {25'd0, last_wa}, 32'd3);
    check("wr3_data", {16'd0, last_wd}, 32'h0000A5C3);
    check("wr3_miso_quiet", {15'd0, rd, stray}, 32'd0);
    core_read(7'd3, "core3");
    frame(8'h03, 16'h0000, 24, -1, rd, stray);
    check("rd3_data", {16'd0, rd}, 32'h0000A5C3);
    check("rd3_stray", {31'd0, stray}, 32'd0);

    // Unmapped write and read.
    w0 = wr_cnt;
    frame(8'hFF, 16'h1234, 24, -1, rd, stray);
    check("unmapped_wr_pulses", wr_cnt - w0, 0);
    frame(8'h7F, 16'h0000, 24, -1, rd, stray);
    check("unmapped_rd", {16'd0, rd}, 32'd0);
    core_read(7'd3, "core3_after_unmapped");

    // Aborted write to register 5.
    frame(8'h85, 16'h5A5A, 24, -1, rd, stray);
    model[5] = 16'h5A5A;
    w0 = wr_cnt; e0 = err_cnt;
    frame(8'h85, 16'hFFFF, 12, -1, rd, stray);
    check("abort_err", err_cnt - e0, 1);
    check("abort_wr", wr_cnt - w0, 0);
    frame(8'h05, 16'h0000, 24, -1, rd, stray);
    check("abort_reg5", {16'd0, rd}, {16'd0, model[5]});
    check("abort_err_once", err_cnt - e0, 1);

    // 30 SCLK pulses: only the first 16 data bits count.
    w0 = wr_cnt;
    frame(8'h86, 16'hC0DE, 30, -1, rd, stray);
    model[6] = 16'hC0DE;
    check("long_pulses", wr_cnt - w0, 1);
    check("long_data", {16'd0, last_wd}, 32'h0000C0DE);
    core_read(7'd6, "core6_long");

    // Reset in the middle of a write frame.
    w0 = wr_cnt;
    frame(8'h86, 16'h1111, 24, 19, rd, stray);
    check("midrst_wr", wr_cnt - w0, 0);
    core_read(7'd6, "core6_midrst");
    w0 = wr_cnt;
    frame(8'h87, 16'hBEEF, 24, -1, rd, stray);
    model[7] = 16'hBEEF;
    check("post_rst_pulses", wr_cnt - w0, 1);
    frame(8'h07, 16'h0000, 24, -1, rd, stray);
    check("post_rst_rd", {16'd0, rd}, 32'h0000BEEF);

    // Randomized frames checked against the register model.
    for (int n = 0; n < 30; n++) begin
      idx   = 7'($urandom_range(0, 23));
      dat   = 16'($urandom);
      is_wr = 1'($urandom);
      w0    = wr_cnt;
      frame({is_wr, idx}, dat, 24, -1, rd, stray);
      if (is_wr) begin
        check("rand_wr_pulses", wr_cnt - w0, (int'(idx) < NR) ? 1 : 0);
        if (int'(idx) < NR) model[idx] = dat;
      end else begin
        check("rand_rd", {16'd0, rd}, {16'd0, expect_rd(idx)});
      end
      check("rand_stray", {31'd0, stray}, 32'd0);
      core_read(7'($urandom_range(0, 20)), "rand_core");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
